// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-block PC generator with redirect priority, BTB/RAS/TAGE prediction and post-redirect bubbles.
module fetch_pc_gen #(
  parameter int ADDR_W = 32,
  parameter int FETCH_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1C000000,
  parameter int REDIR_BUBBLE = 1
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              PcStop,
  input  logic              PcFlash,
  input  logic [ADDR_W-1:0] FlashPc,
  input  logic              BtbAble,
  input  logic [2:0]        BtbType,
  input  logic [ADDR_W-1:0] BtbPc,
  input  logic              RasAble,
  input  logic [ADDR_W-1:0] RasAddr,
  input  logic              TageAble,
  input  logic              TageMode,
  input  logic              ReDirectAble,
  input  logic [ADDR_W-1:0] ReDirEctPc,
  input  logic              PreNextAble,
  input  logic [ADDR_W-1:0] PreNextPc,
  input  logic              IcacheStop,
  output logic [ADDR_W-1:0] OutPc,
  output logic              OutValid
);
  localparam int CW = REDIR_BUBBLE > 0 ? $clog2(REDIR_BUBBLE + 1) : 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(FETCH_BYTES - 1);
  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic redir, taken, fire;
  logic [ADDR_W-1:0] redir_pc, seq_pc, pred_pc;
  always_comb begin
    redir = PcFlash | ReDirectAble | PreNextAble;
    redir_pc = (PcFlash ? FlashPc : ReDirectAble ? ReDirEctPc : PreNextPc) & WORD_MASK;
    taken = BtbAble & ((BtbType >= 3'd1 && BtbType <= 3'd4) | (BtbType == 3'd0 && TageAble && TageMode));
    seq_pc = (OutPc & BLOCK_MASK) + ADDR_W'(FETCH_BYTES);
    pred_pc = taken ? (((BtbType == 3'd3 && RasAble) ? RasAddr : BtbPc) & WORD_MASK) : seq_pc;
    fire = OutValid & ~PcStop & ~IcacheStop;
  end
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      state <= BOOT;
      OutPc <= RESET_PC;
      OutValid <= 1'b0;
      cnt <= '0;
    end else if (redir) begin
      OutPc <= redir_pc;
      state <= REDIR_BUBBLE > 0 ? BUBBLE : RUN;
      OutValid <= (REDIR_BUBBLE == 0);
      cnt <= CW'(REDIR_BUBBLE);
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          OutValid <= 1'b1;
        end
        RUN: if (fire) OutPc <= pred_pc;
        default: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CW'(1)) begin
            state <= RUN;
            OutValid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed and randomized checks of fetch_pc_gen against a cycle-level behavioural model.
module tb_fetch_pc_gen;
  localparam logic [31:0] RST_PC = 32'h1C000000;
  localparam int BUB = 1;
  logic Clk = 1'b0;
  logic Rest = 1'b1;
  logic PcStop, PcFlash, BtbAble, RasAble, TageAble, TageMode, ReDirectAble, PreNextAble, IcacheStop;
  logic [2:0] BtbType;
  logic [31:0] FlashPc, BtbPc, RasAddr, ReDirEctPc, PreNextPc, OutPc;
  logic OutValid;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_pc = RST_PC;
  int m_idle = 1;
  logic m_valid = 1'b0;

  fetch_pc_gen #(.ADDR_W(32), .FETCH_BYTES(16), .RESET_PC(RST_PC), .REDIR_BUBBLE(BUB)) dut (
    .Clk(Clk), .Rest(Rest), .PcStop(PcStop), .PcFlash(PcFlash), .FlashPc(FlashPc),
    .BtbAble(BtbAble), .BtbType(BtbType), .BtbPc(BtbPc), .RasAble(RasAble), .RasAddr(RasAddr),
    .TageAble(TageAble), .TageMode(TageMode), .ReDirectAble(ReDirectAble), .ReDirEctPc(ReDirEctPc),
    .PreNextAble(PreNextAble), .PreNextPc(PreNextPc), .IcacheStop(IcacheStop),
    .OutPc(OutPc), .OutValid(OutValid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a count of remaining idle cycles; the PC advances only when a valid block is accepted.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    logic [31:0] t;
    bit tk;
    tk = BtbAble && ((BtbType >= 1 && BtbType <= 4) || (BtbType == 0 && TageAble && TageMode));
    t = (BtbType == 3 && RasAble) ? RasAddr : BtbPc;
    if (tk) return {t[31:2], 2'b00};
    return 32'((longint'(pc) / 16 + 1) * 16 % 64'h1_0000_0000);
  endfunction

  always @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      m_pc = RST_PC;
      m_idle = 1;
      m_valid = 1'b0;
    end else begin
      if (PcFlash || ReDirectAble || PreNextAble) begin
        m_pc = PcFlash ? FlashPc : ReDirectAble ? ReDirEctPc : PreNextPc;
        m_pc[1:0] = 2'b00;
        m_idle = BUB;
      end else if (m_idle > 0) m_idle--;
      else if (m_valid && !PcStop && !IcacheStop) m_pc = next_pc(m_pc);
      m_valid = (m_idle == 0);
    end
  end

  always @(negedge Clk) begin
    chk("model_pc", OutPc, m_pc);
    chk("model_valid", {31'b0, OutValid}, {31'b0, m_valid});
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    {PcStop, PcFlash, BtbAble, RasAble, TageAble, TageMode, ReDirectAble, PreNextAble, IcacheStop} = '0;
    BtbType = 3'd0;
    {FlashPc, BtbPc, RasAddr, ReDirEctPc, PreNextPc} = '0;
  endtask

  task automatic lit(input string name, input logic [31:0] pc, input logic v);
    chk({name, "_pc"}, OutPc, pc);
    chk({name, "_valid"}, {31'b0, OutValid}, {31'b0, v});
    chk({name, "_model"}, m_pc, pc);
  endtask

  task automatic flash_to(input logic [31:0] a);
    PcFlash = 1'b1;
    FlashPc = a;
    step();
    clr();
    step();
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : 32'h1C000000 + ($urandom & 32'hFFFF);
  endfunction

  initial begin
    clr();
    Rest = 1'b1;
    step();
    step();
    lit("reset", RST_PC, 1'b0);
    Rest = 1'b0;
    step();
    lit("boot_run0", 32'h1C000000, 1'b1);
    step();
    lit("seq1", 32'h1C000010, 1'b1);
    step();
    lit("seq2", 32'h1C000020, 1'b1);
    PcFlash = 1'b1;
    FlashPc = 32'h1C008000;
    ReDirectAble = 1'b1;
    ReDirEctPc = 32'h1C001000;
    step();
    clr();
    lit("flash_bubble", 32'h1C008000, 1'b0);
    step();
    lit("flash_run", 32'h1C008000, 1'b1);
    PreNextAble = 1'b1;
    PreNextPc = 32'h1C000106;
    step();
    clr();
    lit("prenext_bubble", 32'h1C000104, 1'b0);
    step();
    lit("prenext_run", 32'h1C000104, 1'b1);
    step();
    lit("prenext_seq", 32'h1C000110, 1'b1);
    flash_to(32'hFFFFFFF0);
    lit("top_block", 32'hFFFFFFF0, 1'b1);
    step();
    lit("wrap", 32'h00000000, 1'b1);
    flash_to(32'h1C000000);
    BtbAble = 1'b1;
    BtbType = 3'd3;
    RasAble = 1'b1;
    RasAddr = 32'h1C000200;
    BtbPc = 32'h1C000300;
    IcacheStop = 1'b1;
    step();
    lit("stall1", 32'h1C000000, 1'b1);
    step();
    lit("stall2", 32'h1C000000, 1'b1);
    IcacheStop = 1'b0;
    step();
    lit("ras_ret", 32'h1C000200, 1'b1);
    clr();
    BtbAble = 1'b1;
    TageAble = 1'b1;
    BtbPc = 32'h1C000800;
    step();
    lit("tage_nt", 32'h1C000210, 1'b1);
    clr();
    PcFlash = 1'b1;
    FlashPc = 32'h1C000400;
    step();
    clr();
    lit("pre_rst_bubble", 32'h1C000400, 1'b0);
    #2 Rest = 1'b1;
    #1;
    lit("async_rst", RST_PC, 1'b0);
    step();
    Rest = 1'b0;
    step();
    lit("rst_rerun", RST_PC, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      PcStop = ($urandom_range(0, 4) == 0);
      IcacheStop = ($urandom_range(0, 4) == 0);
      PcFlash = ($urandom_range(0, 29) == 0);
      ReDirectAble = ($urandom_range(0, 24) == 0);
      PreNextAble = ($urandom_range(0, 24) == 0);
      BtbAble = $urandom_range(0, 1) == 1;
      BtbType = 3'($urandom_range(0, 7));
      RasAble = $urandom_range(0, 1) == 1;
      TageAble = $urandom_range(0, 1) == 1;
      TageMode = $urandom_range(0, 1) == 1;
      FlashPc = rnd_addr();
      ReDirEctPc = rnd_addr();
      PreNextPc = rnd_addr();
      BtbPc = rnd_addr();
      RasAddr = rnd_addr();
      Rest = Rest ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 199) == 0);
      step();
    end
    clr();
    Rest = 1'b0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter ADDR_W, 32, PC width in bits.
REQ-002 Parameter FETCH_BYTES, 16, fetch-block size in bytes; power of two, >=4.
REQ-003 Parameter RESET_PC, 32'h1C000000, PC value loaded on reset.
REQ-004 Parameter REDIR_BUBBLE, 1, idle cycles inserted after any redirect (0..7).
REQ-005 Clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 Rest  in  1  reset, asynchronous, active-high.
REQ-007 PcStop  in  1  pipeline stall from Ctrl.
REQ-008 PcFlash  in  1  Ctrl flush request.
REQ-009 FlashPc  in  ADDR_W  flush target.
REQ-010 BtbAble  in  1  BTB hit for current block.
REQ-011 BtbType  in  3  0 cond, 1 jump, 2 call, 3 return, 4 indirect, 5-7 reserved.
REQ-012 BtbPc  in  ADDR_W  BTB target.
REQ-013 RasAble  in  1  RAS entry valid.
REQ-014 RasAddr  in  ADDR_W  RAS return target.
REQ-015 TageAble  in  1  TAGE prediction valid.
REQ-016 TageMode  in  1  TAGE direction, 1 = taken.
REQ-017 ReDirectAble  in  1  FTQ mispredict redirect.
REQ-018 ReDirEctPc  in  ADDR_W  FTQ redirect target.
REQ-019 PreNextAble  in  1  predecode correction.
REQ-020 PreNextPc  in  ADDR_W  predecode target.
REQ-021 IcacheStop  in  1  ICache cannot accept a request.
REQ-022 OutPc  out  ADDR_W  fetch-block PC to ICache and BPU, registered.
REQ-023 OutValid  out  1  OutPc is a valid request, registered.

Function
REQ-024 fire = OutValid & ~PcStop & ~IcacheStop; OutPc is delivered exactly on a fire cycle.
REQ-025 FSM states BOOT, RUN, BUBBLE; OutValid=1 only in RUN.
REQ-026 BOOT: PC held at RESET_PC; next cycle -> RUN unless a redirect occurs.
REQ-027 Redirect priority every cycle, any state, regardless of stalls: PcFlash > ReDirectAble > PreNextAble; the winner's target, bits[1:0] cleared, loads PC next cycle.
REQ-028 On redirect: REDIR_BUBBLE>0 -> BUBBLE with counter=REDIR_BUBBLE; REDIR_BUBBLE=0 -> RUN.
REQ-029 BUBBLE: counter decrements each cycle, stalls ignored; at 1 -> RUN; a new redirect in BUBBLE reloads PC and counter.
REQ-030 Redirect coincident with fire: redirect wins; the fired block counts as delivered.
REQ-031 RUN, fire, no redirect: taken = BtbAble & (BtbType in 1..4 | (BtbType==0 & TageAble & TageMode)); reserved types are not-taken.
REQ-032 Taken target: RasAddr if BtbType==3 & RasAble, else BtbPc; bits[1:0] cleared.
REQ-033 Not-taken: next PC = (PC & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^ADDR_W (wraps to 0).
REQ-034 RUN without fire and without redirect: PC and state hold; predictor inputs ignored.
REQ-035 No combinational path from any input to OutPc or OutValid.
REQ-036 Counter width = clog2(REDIR_BUBBLE+1), minimum 1 bit.

Reset
REQ-037 Rest=1 immediately, asynchronously: OutPc=RESET_PC, OutValid=0, state BOOT, counter 0; this aborts any operation, including BUBBLE.
REQ-038 On release, BOOT is held for one cycle, then RUN drives OutValid=1 with OutPc=RESET_PC.

Verification
REQ-039 Reset release, no stalls, no predictions -> OutPc 0x1C000000, 0x1C000010, 0x1C000020 on consecutive RUN cycles.
REQ-040 Same cycle: PcFlash with FlashPc 0x1C008000, ReDirectAble with 0x1C001000 -> OutPc 0x1C008000 and OutValid=0 for 1 cycle, then OutValid=1.
REQ-041 PreNextPc 0x1C000106 -> OutPc 0x1C000104; following sequential block 0x1C000110.
REQ-042 PC 0xFFFFFFF0, fire, not-taken -> OutPc 0x00000000.
REQ-043 BtbType=3, RasAble=1, RasAddr 0x1C000200, IcacheStop=1 for 2 cycles then 0 -> PC holds 2 cycles, then 0x1C000200.
REQ-044 BtbType=0, TageAble=1, TageMode=0 -> sequential; assert Rest mid-BUBBLE -> OutPc 0x1C000000, OutValid=0 immediately.
